dmem_arbiter: RTL and testbench

//  Shares one single-port synchronous data RAM between two requesters.
//  M0 is the CPU data port (addr = aluout, wdata = store data, wmem); M1 is the debug/program loader.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/rr_pick2.sv | 13 +
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic M0_ID      = 1'b0;
  localparam logic M1_ID      = 1'b1;
  localparam int   RD_LAT_MAX = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the RAM port; the arbiter takes the slave side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m0_stall;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_stall,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_stall,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the one not granted last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_id,
  output logic gnt_valid
);
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = (req0 & req1) ? ~last : req1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto one single-port synchronous RAM with a req/ack handshake
// and read-latency wait states.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output logic           busy,
  output logic           grant_id
);
  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick_id, pick_valid;
  logic          resp;

  rr_pick2 u_pick (
    .req0      (bus.m0_req),
    .req1      (bus.m1_req),
    .last      (last_q),
    .gnt_id    (pick_id),
    .gnt_valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_id;
          last_d  = pick_id;
          we_d    = pick_id ? bus.m1_we    : bus.m0_we;
          addr_d  = pick_id ? bus.m1_addr  : bus.m0_addr;
          wdata_d = pick_id ? bus.m1_wdata : bus.m0_wdata;
          rdata_d = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 3'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // cnt reaches zero exactly RD_LAT cycles after the strobe
        if (cnt_q == 3'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= M1_ID;
      gnt_q   <= M0_ID;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign resp          = (state_q == RESP);
  assign bus.m0_ack    = resp & (gnt_q == M0_ID);
  assign bus.m1_ack    = resp & (gnt_q == M1_ID);
  assign bus.m0_rdata  = bus.m0_ack ? rdata_q : '0;
  assign bus.m1_rdata  = bus.m1_ack ? rdata_q : '0;
  assign bus.m0_stall  = bus.m0_req & ~bus.m0_ack;

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = bus.mem_en & we_q;
  assign bus.mem_addr  = bus.mem_en ? addr_q  : '0;
  assign bus.mem_wdata = bus.mem_en ? wdata_q : '0;

  assign busy     = (state_q != IDLE);
  assign grant_id = gnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a RAM model and a scoreboard.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  parameter int RD_LAT = 1;
  localparam int BOUND = 2 * (3 + RD_LAT);

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  logic busy, grant_id;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock    (clk),
    .reset    (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // RAM model: read data appears RD_LAT cycles after the strobe, garbage otherwise
  logic [DW-1:0] ram   [0:255];
  logic [DW-1:0] rpipe [0:3];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    rpipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[7:0]] : 32'hBAD0_0BAD;
    for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.mem_rdata = rpipe[RD_LAT-1];

  initial begin
    #1ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit m, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      step();
      n++;
      if ((m ? bus.m1_ack : bus.m0_ack) === 1'b1) return;
    end
    n = -1;
  endtask

  task automatic wait_any(input int bound, output int who);
    int n;
    n   = 0;
    who = -1;
    while (n < bound) begin
      step();
      n++;
      if (bus.m0_ack === 1'b1 || bus.m1_ack === 1'b1) begin
        chk("tie_single_ack", {bus.m0_ack, bus.m1_ack} == 2'b11, 1'b0);
        who = (bus.m1_ack === 1'b1) ? 1 : 0;
        return;
      end
    end
  endtask

  // stress scoreboard state
  bit            pend   [2];
  bit            pwe    [2];
  logic [AW-1:0] paddr  [2];
  logic [DW-1:0] pwd    [2];
  int            age    [2];
  logic [DW-1:0] refm   [0:15];

  initial begin
    int n, who, en_since, ack_cnt, en_cnt;
    bit a [2];
    bit en, prev_en, issue;

    rst = 1'b1; ram_clr = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    repeat (3) step();
    ram_clr = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_m0_ack", bus.m0_ack, 1'b0);
    chk("rst_m1_ack", bus.m1_ack, 1'b0);
    chk("rst_stall", bus.m0_stall, 1'b0);
    rst = 1'b0;
    step();

    // lone M0 write
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h10; bus.m0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_stall_t", bus.m0_stall, 1'b1);
    step();
    chk("wr_mem_en", bus.mem_en, 1'b1);
    chk("wr_mem_we", bus.mem_we, 1'b1);
    chk("wr_mem_addr", bus.mem_addr, 32'h10);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("wr_stall_t1", bus.m0_stall, 1'b1);
    chk("wr_no_ack_t1", bus.m0_ack, 1'b0);
    step();
    chk("wr_ack_t2", bus.m0_ack, 1'b1);
    chk("wr_m1_quiet", bus.m1_ack, 1'b0);
    chk("wr_stall_t2", bus.m0_stall, 1'b0);
    chk("wr_rdata_zero", bus.m0_rdata, 32'h0);
    chk("wr_mem_en_off", bus.mem_en, 1'b0);
    bus.m0_req = 0;
    step();
    chk("wr_ack_gone", bus.m0_ack, 1'b0);
    chk("wr_idle", busy, 1'b0);
    chk("wr_ram", ram[8'h10], 32'hDEADBEEF);

    // lone M0 read
    bus.m0_req = 1; bus.m0_we = 0;
    wait_ack(1'b0, 20, n);
    chk("rd_latency", n, 2 + RD_LAT);
    chk("rd_data", bus.m0_rdata, 32'hDEADBEEF);
    bus.m0_req = 0;
    step();
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h4; bus.m0_wdata = 32'hCAFE0004;
    wait_ack(1'b0, 20, n);
    chk("wr4_latency", n, 2);
    bus.m0_req = 0;
    step();

    // simultaneous requests right after reset
    rst = 1'b1;
    step(); step();
    chk("rst2_busy", busy, 1'b0);
    rst = 1'b0;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h4;
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h8; bus.m1_wdata = 32'h55;
    wait_ack(1'b0, 20, n);
    chk("tie_m0_first", n, 2 + RD_LAT);
    chk("tie_m0_rdata", bus.m0_rdata, 32'hCAFE0004);
    chk("tie_m1_waits", bus.m1_ack, 1'b0);
    step();
    chk("tie_gap", bus.mem_en, 1'b0);
    step();
    chk("tie_m1_en", bus.mem_en, 1'b1);
    chk("tie_m1_addr", bus.mem_addr, 32'h8);
    chk("tie_m1_we", bus.mem_we, 1'b1);
    chk("tie_m1_grant", grant_id, 1'b1);
    wait_ack(1'b1, 5, n);
    chk("tie_m1_ack", n, 1);
    for (int r = 0; r < 4; r++) begin
      wait_any(20, who);
      chk("tie_alternate", who, r % 2);
    end
    bus.m0_req = 0; bus.m1_req = 0;
    step(); step();
    chk("tie_ram8", ram[8'h8], 32'h55);

    // inputs changed after latching must not reach the RAM
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h8; bus.m1_wdata = 32'h77;
    @(posedge clk); #1;
    bus.m1_addr = 32'h20; bus.m1_wdata = 32'h99;
    step();
    chk("proto_addr", bus.mem_addr, 32'h8);
    chk("proto_wdata", bus.mem_wdata, 32'h77);
    wait_ack(1'b1, 5, n);
    chk("proto_ack", n, 1);
    chk("proto_no_m0", bus.m0_ack, 1'b0);
    bus.m1_req = 0;
    step();
    chk("proto_ram8", ram[8'h8], 32'h77);
    chk("proto_ram20", ram[8'h20], 32'h0);

    // reset during a read wait state
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h10;
    step(); step();
    chk("abort_busy_wait", busy, 1'b1);
    rst = 1'b1; bus.m1_req = 0;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_no_ack", bus.m1_ack, 1'b0);
    chk("abort_mem_en", bus.mem_en, 1'b0);
    chk("abort_grant", grant_id, 1'b0);
    rst = 1'b0;
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h30; bus.m0_wdata = 32'hABCD;
    wait_ack(1'b0, 20, n);
    chk("abort_next_lat", n, 2);
    bus.m0_req = 0;
    step();
    chk("abort_next_ram", ram[8'h30], 32'hABCD);

    // random stress on 0x40..0x4F (cleared, untouched so far)
    for (int i = 0; i < 16; i++) refm[i] = '0;
    for (int m = 0; m < 2; m++) begin pend[m] = 0; age[m] = 0; end
    en_since = 0; ack_cnt = 0; en_cnt = 0; prev_en = 0;
    for (int c = 0; c < 3000; c++) begin
      issue = (c < 2950);
      step();
      a[0] = bus.m0_ack; a[1] = bus.m1_ack; en = bus.mem_en;
      chk("st_one_ack", a[0] & a[1], 1'b0);
      chk("st_en_gap", en & prev_en, 1'b0);
      prev_en = en;
      if (en) begin en_since++; en_cnt++; end
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) age[m]++;
        if (a[m]) begin
          ack_cnt++;
          chk("st_ack_pending", pend[m], 1'b1);
          chk("st_en_per_ack", en_since, 1);
          en_since = 0;
          if (pend[m]) begin
            chk("st_ack_age", age[m] <= BOUND, 1'b1);
            if (pwe[m]) refm[paddr[m][3:0]] = pwd[m];
            else chk("st_rdata", m ? bus.m1_rdata : bus.m0_rdata, refm[paddr[m][3:0]]);
          end
          pend[m] = 0;
        end else if (pend[m] && age[m] > BOUND) begin
          chk("st_timeout", age[m], BOUND);
          pend[m] = 0;
        end
        if (!pend[m] && issue && $urandom_range(0, 2) != 0) begin
          pend[m]  = 1;
          age[m]   = 0;
          pwe[m]   = 1'($urandom_range(0, 1));
          paddr[m] = 32'h40 + 32'($urandom_range(0, 15));
          pwd[m]   = $urandom;
        end
      end
      bus.m0_req = pend[0]; bus.m0_we = pwe[0]; bus.m0_addr = paddr[0]; bus.m0_wdata = pwd[0];
      bus.m1_req = pend[1]; bus.m1_we = pwe[1]; bus.m1_addr = paddr[1]; bus.m1_wdata = pwd[1];
    end
    chk("st_drained0", pend[0], 1'b0);
    chk("st_drained1", pend[1], 1'b0);
    chk("st_en_total", en_cnt, ack_cnt);
    chk("st_activity", ack_cnt > 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
